// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared FSM type, unity gain constant and signed clamp helper for the EQ band mixer
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } eq_state_t;

    localparam logic signed [15:0] GAIN_UNITY = 16'sh4000;

    // Clamp a signed value into the range of a w-bit signed number; callers truncate the result
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - control, gain write, band input and mixed output signals of the EQ band mixer
interface eq_band_mixer_if #(
    parameter int NUM_BANDS = 4,
    parameter int IN_W      = 48,
    parameter int OUT_W     = 24,
    parameter int GAIN_W    = 16
);
    logic                     audio_en;
    logic                     gain_wr_en;
    logic [3:0]               gain_select;
    logic signed [GAIN_W-1:0] gain_wr_data;
    logic                     in_valid;
    logic signed [IN_W-1:0]   l_band_in [NUM_BANDS];
    logic signed [IN_W-1:0]   r_band_in [NUM_BANDS];
    logic signed [OUT_W-1:0]  l_data_out;
    logic signed [OUT_W-1:0]  r_data_out;
    logic                     data_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output audio_en, gain_wr_en, gain_select, gain_wr_data, in_valid, l_band_in, r_band_in,
        input  l_data_out, r_data_out, data_valid, busy, overrun
    );

    modport slave (
        input  audio_en, gain_wr_en, gain_select, gain_wr_data, in_valid, l_band_in, r_band_in,
        output l_data_out, r_data_out, data_valid, busy, overrun
    );

endinterface

// File: rtl/eq_mac_lane.sv
// rtl/eq_mac_lane.sv - one channel of band capture, gain multiply-accumulate and round/saturate
module eq_mac_lane
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int IN_W      = 48,
    parameter int COEF_FRAC = 15,
    parameter int OUT_W     = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14,
    parameter int IDX_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic                     rnd_en,
    input  logic [IDX_W-1:0]         band_idx,
    input  logic signed [GAIN_W-1:0] gain,
    input  logic signed [IN_W-1:0]   band_in [NUM_BANDS],
    output logic signed [OUT_W-1:0]  data_out
);
    localparam int PROD_W = OUT_W + GAIN_W;
    localparam int ACC_W  = OUT_W + GAIN_W + $clog2(NUM_BANDS);
    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W + 1 - GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC - 1){1'b0}}};

    logic signed [IN_W-1:0]   band_q [NUM_BANDS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [OUT_W-1:0]  term;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [OUT_W-1:0]  rnd_sat;

    // Bring the selected band back to sample scale, clamp it, and weight it by its gain
    always_comb begin
        term = OUT_W'(sat_to_width(64'(band_q[band_idx]) >>> COEF_FRAC, OUT_W));
        prod = PROD_W'(term) * PROD_W'(gain);
    end

    // Round half up out of the gain fraction, then clamp so the output never wraps
    always_comb begin
        rnd_sum = (ACC_W + 1)'(acc_q) + RND_HALF;
        rnd_sat = OUT_W'(sat_to_width(64'(rnd_sum >>> GAIN_FRAC), OUT_W));
    end

    // Capture bands, accumulate one band per MAC clock, register the mixed sample in ROUND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                band_q[i] <= '0;
            end
            acc_q    <= '0;
            data_out <= '0;
        end else if (flush) begin
            acc_q    <= '0;
            data_out <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    band_q[i] <= band_in[i];
                end
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_q + ACC_W'(prod);
            end
            if (rnd_en) begin
                data_out <= rnd_sat;
            end
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain, band summing and 24-bit round/saturate after the FIR bank
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int IN_W      = 48,
    parameter int COEF_FRAC = 15,
    parameter int OUT_W     = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic          clk,
    input  logic          reset,
    eq_band_mixer_if.slave bus
);
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    eq_state_t                state_q;
    eq_state_t                state_d;
    logic [IDX_W-1:0]         band_idx_q;
    logic signed [GAIN_W-1:0] gain_q      [NUM_BANDS];
    logic signed [GAIN_W-1:0] gain_snap_q [NUM_BANDS];
    logic                     gain_hit;
    logic                     capture;
    logic                     acc_en;
    logic                     rnd_en;
    logic                     flush;
    logic                     drop;
    logic                     data_valid_q;
    logic                     overrun_q;

    assign gain_hit = bus.gain_wr_en && (int'(bus.gain_select) < NUM_BANDS);

    // Live gain registers: writes land on the next clock at any time and never stall the datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                gain_q[i] <= GAIN_W'(GAIN_UNITY);
            end
        end else if (gain_hit) begin
            gain_q[bus.gain_select[IDX_W-1:0]] <= bus.gain_wr_data;
        end
    end

    // Freeze the gains at capture so a write during a frame only affects the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                gain_snap_q[i] <= GAIN_W'(GAIN_UNITY);
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                gain_snap_q[i] <= gain_q[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: audio_en low aborts from any state
    always_comb begin
        state_d = state_q;
        if (!bus.audio_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid) state_d = MAC;
                MAC:     if (band_idx_q == LAST_IDX) state_d = ROUND;
                ROUND:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: strobes shared by both lanes plus busy and the overrun trigger
    always_comb begin
        flush    = !bus.audio_en;
        capture  = bus.audio_en && (state_q == IDLE) && bus.in_valid;
        acc_en   = bus.audio_en && (state_q == MAC);
        rnd_en   = bus.audio_en && (state_q == ROUND);
        drop     = bus.audio_en && (state_q != IDLE) && bus.in_valid;
        bus.busy = (state_q != IDLE);
    end

    // Band index walk, one-clock data_valid strobe and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            band_idx_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (flush) begin
            band_idx_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (capture) begin
                band_idx_q <= '0;
            end else if (acc_en) begin
                band_idx_q <= band_idx_q + IDX_W'(1);
            end
            data_valid_q <= rnd_en;
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;

    eq_mac_lane #(
        .NUM_BANDS (NUM_BANDS),
        .IN_W      (IN_W),
        .COEF_FRAC (COEF_FRAC),
        .OUT_W     (OUT_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .IDX_W     (IDX_W)
    ) u_lane_l (
        .clk      (clk),
        .rst      (reset),
        .flush    (flush),
        .load     (capture),
        .acc_en   (acc_en),
        .rnd_en   (rnd_en),
        .band_idx (band_idx_q),
        .gain     (gain_snap_q[band_idx_q]),
        .band_in  (bus.l_band_in),
        .data_out (bus.l_data_out)
    );

    eq_mac_lane #(
        .NUM_BANDS (NUM_BANDS),
        .IN_W      (IN_W),
        .COEF_FRAC (COEF_FRAC),
        .OUT_W     (OUT_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .IDX_W     (IDX_W)
    ) u_lane_r (
        .clk      (clk),
        .rst      (reset),
        .flush    (flush),
        .load     (capture),
        .acc_en   (acc_en),
        .rnd_en   (rnd_en),
        .band_idx (band_idx_q),
        .gain     (gain_snap_q[band_idx_q]),
        .band_in  (bus.r_band_in),
        .data_out (bus.r_data_out)
    );

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - self-checking bench for eq_band_mixer
module tb_eq_band_mixer;

    localparam longint ONE = 64'sh100000 <<< 15;

    typedef struct {
        longint l;
        longint r;
        int     due;
    } exp_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    int     cyc     = 0;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     last_acc = -100;
    int     mg [4];
    logic   model_ovr = 1'b0;
    exp_t   exp_q [$];
    exp_t   cur;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    eq_band_mixer_if bus ();

    eq_band_mixer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clampv(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Mixed sample from the arithmetic rules: scale, clamp, weight, sum, round half up, clamp
    function automatic longint mix(input longint b [4], input int g [4]);
        longint acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc += clampv(b[i] >>> 15, 24) * longint'(g[i]);
        end
        return clampv((acc + 8192) >>> 14, 24);
    endfunction

    // Compare process: every data_valid must match the oldest expected frame at its due cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_data_valid: data_valid=1 at cycle %0d, no frame expected", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("latency", longint'(cyc), longint'(cur.due));
                    chk("l_data_out", longint'(bus.l_data_out), cur.l);
                    chk("r_data_out", longint'(bus.r_data_out), cur.r);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_data_valid: data_valid=0 at cycle %0d, required at %0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input longint l0, input longint l1, input longint l2, input longint l3,
                        input longint r0, input longint r1, input longint r2, input longint r3);
        longint lb [4];
        longint rb [4];
        exp_t   e;
        lb[0] = l0; lb[1] = l1; lb[2] = l2; lb[3] = l3;
        rb[0] = r0; rb[1] = r1; rb[2] = r2; rb[3] = r3;
        for (int i = 0; i < 4; i++) begin
            bus.l_band_in[i] = 48'(lb[i]);
            bus.r_band_in[i] = 48'(rb[i]);
        end
        bus.in_valid = 1'b1;
        if (cyc - last_acc >= 6) begin
            e.l   = mix(lb, mg);
            e.r   = mix(rb, mg);
            e.due = cyc + 6;
            exp_q.push_back(e);
            last_acc = cyc;
        end else begin
            model_ovr = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wgain(input int sel, input int val);
        bus.gain_wr_en   = 1'b1;
        bus.gain_select  = 4'(sel);
        bus.gain_wr_data = 16'(val);
        @(posedge clk);
        #1;
        bus.gain_wr_en = 1'b0;
        if (sel < 4) mg[sel] = val;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: %0d frames still pending at cycle %0d, required 0", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_l_data_out"}, longint'(bus.l_data_out), 0);
        chk({tag, "_r_data_out"}, longint'(bus.r_data_out), 0);
        chk({tag, "_data_valid"}, longint'(bus.data_valid), 0);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_overrun"}, longint'(bus.overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.audio_en     = 1'b0;
        bus.gain_wr_en   = 1'b0;
        bus.gain_select  = 4'd0;
        bus.gain_wr_data = 16'd0;
        bus.in_valid     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.l_band_in[i] = '0;
            bus.r_band_in[i] = '0;
            mg[i] = 16384;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk);
        #1;
        bus.audio_en = 1'b1;

        // Unity passthrough and latency
        send(ONE, 0, 0, 0, -(64'sh1234 <<< 15), 0, 0, 0);
        wait_done();
        chk("unity_l", longint'(bus.l_data_out), 64'sh100000);
        chk("unity_r", longint'(bus.r_data_out), -4660);

        // Half gain and round half up on both signs
        wgain(0, 'h2000);
        send(ONE, 0, 0, 0, 0, 0, 0, 0);
        wait_done();
        chk("half_gain_l", longint'(bus.l_data_out), 64'sh080000);
        send(3 <<< 15, 0, 0, 0, -(64'sd3 <<< 15), 0, 0, 0);
        wait_done();
        chk("round_pos_l", longint'(bus.l_data_out), 2);
        chk("round_neg_r", longint'(bus.r_data_out), -1);
        wgain(0, 'h4000);

        // Output and term saturation
        send(64'sh600000 <<< 15, 64'sh600000 <<< 15, 64'sh600000 <<< 15, 64'sh600000 <<< 15,
             -(64'sh400000 <<< 15), -(64'sh400000 <<< 15), -(64'sh400000 <<< 15), -(64'sh400000 <<< 15));
        wait_done();
        chk("sat_pos_l", longint'(bus.l_data_out), 64'sh7FFFFF);
        chk("sat_neg_r", longint'(bus.r_data_out), -8388608);
        send(64'sh7FFF_FFFF_FFFF, 0, 0, 0, -(64'sd1 <<< 47), 0, 0, 0);
        wait_done();
        chk("term_clamp_l", longint'(bus.l_data_out), 64'sh7FFFFF);
        chk("term_clamp_r", longint'(bus.r_data_out), -8388608);
        send(64'sh7FFF_FFFF_FFFF, -(64'sh7FFFFF <<< 15), 0, 0, -(64'sd1 <<< 47), 64'sh7FFFFF <<< 15, 0, 0);
        wait_done();
        chk("term_cancel_l", longint'(bus.l_data_out), 0);
        chk("term_cancel_r", longint'(bus.r_data_out), -1);

        // Overrun: second strobe two clocks later is dropped
        send(64'sh123456 <<< 15, 0, 0, 0, 64'sh654321 <<< 15, 0, 0, 0);
        idle(1);
        send(64'sh111 <<< 15, 0, 0, 0, 64'sh222 <<< 15, 0, 0, 0);
        wait_done();
        chk("overrun_keep_l", longint'(bus.l_data_out), 64'sh123456);
        chk("overrun_keep_r", longint'(bus.r_data_out), 64'sh654321);
        chk("overrun_flag", longint'(bus.overrun), longint'(model_ovr));

        // Throughput boundary: strobe in the ROUND clock dropped, the next one accepted
        send(64'sh10 <<< 15, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        send(64'sh20 <<< 15, 0, 0, 0, 0, 0, 0, 0);
        send(64'sh30 <<< 15, 0, 0, 0, 0, 0, 0, 0);
        wait_done();
        chk("back_to_back_l", longint'(bus.l_data_out), 64'sh30);

        // Gain write during MAC affects only the next frame
        send(ONE, 0, 0, 0, ONE, 0, 0, 0);
        wgain(0, 0);
        wait_done();
        chk("midframe_cur_l", longint'(bus.l_data_out), 64'sh100000);
        send(ONE, 0, 0, 0, ONE, 0, 0, 0);
        wait_done();
        chk("midframe_next_l", longint'(bus.l_data_out), 0);

        // Abort during MAC: no data_valid, outputs and overrun cleared, gains kept
        send(ONE, 64'sh10 <<< 15, 0, 0, 0, -(64'sh20 <<< 15), 0, 0);
        idle(1);
        bus.audio_en = 1'b0;
        exp_q.delete();
        last_acc  = -100;
        model_ovr = 1'b0;
        @(posedge clk);
        #1;
        bus.audio_en = 1'b1;
        chk_cleared("abort");
        idle(8);
        send(ONE, 64'sh10 <<< 15, 0, 0, 0, -(64'sh20 <<< 15), 0, 0);
        wait_done();
        chk("abort_gain_kept_l", longint'(bus.l_data_out), 64'sh10);
        chk("abort_gain_kept_r", longint'(bus.r_data_out), -32);

        // Mixed gains, out-of-range selects ignored, back-to-back frames
        wgain(0, 'h4000);
        wgain(4, 0);
        wgain(15, 'h7FFF);
        wgain(1, -'h2000);
        wgain(2, 'h6000);
        wgain(3, 'h1000);
        send(ONE + 'h4000, 64'sh7FF <<< 15, -(64'sd5 <<< 15), 64'sh3FFFFF <<< 15,
             -1, (64'sh1FFF <<< 15) + 'h7FFF, 0, -(64'sh2AAAAA <<< 15));
        idle(5);
        send(-(64'sh333333 <<< 15), 64'sh7FFFFF <<< 15, 64'sh0ABCDE <<< 15, -(64'sd7 <<< 15),
             64'sh1 <<< 15, 64'sh3 <<< 15, -(64'sh5 <<< 15), 64'sh7FFF_FFFF_FFFF);
        idle(5);
        send(-(64'sd1 <<< 47), -(64'sd1 <<< 47), -(64'sd1 <<< 47), -(64'sd1 <<< 47),
             64'sh2 <<< 15, -(64'sh3 <<< 15), 64'sh1 <<< 15, -(64'sh1 <<< 15));
        wait_done();

        // Async reset mid-MAC: everything back to reset values, gains unity again
        send(ONE, 0, 0, 0, ONE, 0, 0, 0);
        idle(1);
        send(ONE, 0, 0, 0, ONE, 0, 0, 0);
        exp_q.delete();
        last_acc  = -100;
        model_ovr = 1'b0;
        for (int i = 0; i < 4; i++) mg[i] = 16384;
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk_cleared("async_reset");
        @(posedge clk);
        #1;
        send(0, ONE, 0, 0, 0, 0, ONE, 0);
        wait_done();
        chk("reset_unity_l", longint'(bus.l_data_out), 64'sh100000);
        chk("reset_unity_r", longint'(bus.r_data_out), 64'sh100000);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
